mac_operand_sequencer: RTL and testbench

Operand sequencer and result collector for the 4x4 MAC unit (`top`). It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It drives them into the MAC one pair per cycle, clears the MAC accumulator between vectors, and returns each VEC_LEN-element dot product as a handshaked 8-bit result. It is the initiator/reader end of the MAC interface, sitting between an upstream data source and `top`.

---
 rtl/mac_operand_sequencer.sv | 157 +++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// rtl/mac_operand_sequencer.sv - operand FIFO, MAC feed sequencer and dot-product result register
module mac_operand_sequencer #(
    parameter int VEC_LEN    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] mac_a,
    output logic [3:0] mac_b,
    output logic       mac_rst,
    input  logic [7:0] mac_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0] LAST_CNT = 4'(VEC_LEN);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN1,
        ST_DRAIN2,
        ST_RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [7:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       mac_a_q, mac_a_d;
    logic [3:0]       mac_b_q, mac_b_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;
    logic             full, empty, push, pop;
    logic [7:0]       head;

    assign full     = (level_q == FULL_LEVEL);
    assign empty    = (level_q == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == ST_FEED) && !empty && (cnt_q < LAST_CNT);
    assign head     = fifo_q[rd_ptr_q];

    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_rst   = rst || (state_q == ST_CLEAR);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = ((state_q == ST_FEED) && (cnt_q != 4'd0)) ||
                       (state_q == ST_DRAIN1) || (state_q == ST_DRAIN2) ||
                       (state_q == ST_RESULT);

    // Entries are stored as {a, b}; pointers wrap naturally since depth is a power of two.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {in_a, in_b};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (PTR_W + 1)'(1);
        end
    end

    // Operands default to zero so idle cycles add a zero product to the MAC.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mac_a_d     = 4'd0;
        mac_b_d     = 4'd0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d   = 4'd0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (pop) begin
                    mac_a_d = head[7:4];
                    mac_b_d = head[3:0];
                    cnt_d   = cnt_q + 4'd1;
                    if ((cnt_q + 4'd1) == LAST_CNT) begin
                        state_d = ST_DRAIN1;
                    end
                end
            end
            ST_DRAIN1: begin
                state_d = ST_DRAIN2;
            end
            ST_DRAIN2: begin
                res_data_d  = mac_out;
                res_valid_d = 1'b1;
                state_d     = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= 4'd0;
            mac_a_q     <= 4'd0;
            mac_b_q     <= 4'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= fifo_d[i];
        end
    end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb/tb_mac_operand_sequencer.sv - scoreboard bench for mac_operand_sequencer (VEC_LEN 4 and 1 builds)
module tb_mac_operand_sequencer;
    logic       clk;
    logic       rst;

    logic       in_valid, in_ready, mac_rst, res_valid, res_ready, busy;
    logic [3:0] in_a, in_b, mac_a, mac_b;
    logic [7:0] mac_out, res_data;

    logic       in_valid1, in_ready1, mac_rst1, res_valid1, res_ready1, busy1;
    logic [3:0] in_a1, in_b1, mac_a1, mac_b1;
    logic [7:0] mac_out1, res_data1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] acc;
    int         npair;
    int         res_count = 0;
    logic [7:0] last_res = 8'd0;
    logic       hold_v;
    logic [7:0] hold_d;

    logic [7:0] exp1_q[$];
    int         clr_run1;
    int         res1_n = 0;
    logic [7:0] res1 [4];

    mac_operand_sequencer #(.VEC_LEN(4), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b), .mac_rst(mac_rst),
        .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy)
    );

    mac_operand_sequencer #(.VEC_LEN(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .mac_a(mac_a1), .mac_b(mac_b1), .mac_rst(mac_rst1),
        .mac_out(mac_out1), .res_valid(res_valid1), .res_ready(res_ready1),
        .res_data(res_data1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural MAC: registered 8-bit wrapping accumulator.
    always @(posedge clk) begin
        mac_out  <= mac_rst  ? 8'd0 : mac_out  + 8'(mac_a)  * 8'(mac_b);
        mac_out1 <= mac_rst1 ? 8'd0 : mac_out1 + 8'(mac_a1) * 8'(mac_b1);
    end

    // Scoreboard for the VEC_LEN=4 instance, sampled on the falling edge.
    initial begin
        acc = 8'd0; npair = 0; hold_v = 1'b0; hold_d = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete(); acc = 8'd0; npair = 0; hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    checks++;
                    if (res_valid !== 1'b1 || res_data !== hold_d) begin
                        errors++;
                        $display("FAIL result_hold: valid=%b data=%h required valid=1 data=%h", res_valid, res_data, hold_d);
                    end
                end
                if (in_valid && in_ready) begin
                    acc = acc + 8'(in_a) * 8'(in_b);
                    npair++;
                    if (npair == 4) begin
                        exp_q.push_back(acc);
                        acc = 8'd0; npair = 0;
                    end
                end
                if (res_valid && res_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL result_unexpected: got %h with no expected result queued", res_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (res_data !== e) begin
                            errors++;
                            $display("FAIL result_value: got %h required %h", res_data, e);
                        end
                    end
                    last_res = res_data;
                    res_count++;
                end
                hold_v = res_valid && !res_ready;
                hold_d = res_data;
            end
        end
    end

    // Scoreboard for the VEC_LEN=1 instance; also counts CLEAR cycles before each result.
    initial begin
        clr_run1 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp1_q.delete(); clr_run1 = 0;
            end else begin
                if (mac_rst1) clr_run1++;
                if (in_valid1 && in_ready1) exp1_q.push_back(8'(in_a1) * 8'(in_b1));
                if (res_valid1 && res_ready1) begin
                    checks++;
                    if (exp1_q.size() == 0) begin
                        errors++;
                        $display("FAIL v1_result_unexpected: got %h", res_data1);
                    end else begin
                        logic [7:0] e;
                        e = exp1_q.pop_front();
                        if (res_data1 !== e) begin
                            errors++;
                            $display("FAIL v1_result_value: got %h required %h", res_data1, e);
                        end
                    end
                    checks++;
                    if (clr_run1 != 1) begin
                        errors++;
                        $display("FAIL v1_clear_cycles: got %0d required 1", clr_run1);
                    end
                    clr_run1 = 0;
                    if (res1_n < 4) res1[res1_n] = res_data1;
                    res1_n++;
                end
            end
        end
    end

    task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
        int t = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pair1(input logic [3:0] a, input logic [3:0] b);
        int t = 0;
        in_valid1 = 1'b1; in_a1 = a; in_b1 = b;
        @(negedge clk);
        while (!in_ready1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready1) begin
            checks++; errors++;
            $display("FAIL send1_timeout: in_ready1=%b required 1", in_ready1);
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_count(input int target);
        int t = 0;
        while (res_count < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || mac_rst !== 1'b1 || res_valid !== 1'b0 || res_data !== 8'd0 ||
            busy !== 1'b0 || mac_a !== 4'd0 || mac_b !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: rdy=%b mrst=%b rv=%b rd=%h busy=%b a=%h b=%h required 0 1 0 00 0 0 0",
                     in_ready, mac_rst, res_valid, res_data, busy, mac_a, mac_b);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || mac_rst !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b mrst=%b busy=%b rv=%b required 1 1 0 0", in_ready, mac_rst, busy, res_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (mac_rst !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_feed_idle: mrst=%b busy=%b required 0 0", mac_rst, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int t = 0;
        res_ready = 1'b1;
        send_pair(4'd1, 4'd2); send_pair(4'd3, 4'd10); send_pair(4'd1, 4'd2); send_pair(4'd0, 4'd0);
        @(negedge clk);
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h22) begin
            errors++;
            $display("FAIL basic_result: valid=%b data=%h required 1 22", res_valid, res_data);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || mac_rst !== 1'b1) begin
            errors++;
            $display("FAIL basic_pulse_clear: valid=%b mac_rst=%b required 0 1", res_valid, mac_rst);
        end
        @(negedge clk);
        checks++;
        if (mac_rst !== 1'b0) begin
            errors++;
            $display("FAIL basic_clear_len: mac_rst=%b required 0", mac_rst);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int rise0 = 0;
        int rise1 = 0;
        int n = 0;
        int c0 = res_count;
        res_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) send_pair(4'd15, 4'd15);
                send_pair(4'd1, 4'd2); send_pair(4'd3, 4'd10); send_pair(4'd1, 4'd2); send_pair(4'd0, 4'd0);
            end
            begin
                int cyc = 0;
                logic prev = 1'b0;
                while (n < 2 && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                    if (res_valid && !prev) begin
                        if (n == 0) rise0 = cyc; else rise1 = cyc;
                        n++;
                    end
                    prev = res_valid;
                end
            end
        join
        checks++;
        if (n < 2 || (rise1 - rise0) != 8) begin
            errors++;
            $display("FAIL throughput: results=%0d spacing=%0d required 2 results spaced 8", n, rise1 - rise0);
        end
        wait_count(c0 + 2);
        checks++;
        if (res_count != c0 + 2 || last_res !== 8'h22) begin
            errors++;
            $display("FAIL b2b_results: count=%0d last=%h required %0d 22", res_count, last_res, c0 + 2);
        end
    endtask

    task automatic test_bubbles;
        logic [3:0] va [4];
        logic [3:0] vb [4];
        int c0 = res_count;
        va[0] = 4'd1; vb[0] = 4'd2; va[1] = 4'd3; vb[1] = 4'd10;
        va[2] = 4'd1; vb[2] = 4'd2; va[3] = 4'd0; vb[3] = 4'd0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_pair(va[i], vb[i]);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (mac_a !== va[i] || mac_b !== vb[i]) begin
                errors++;
                $display("FAIL bubble_feed%0d: a=%h b=%h required %h %h", i, mac_a, mac_b, va[i], vb[i]);
            end
            @(negedge clk);
            checks++;
            if (mac_a !== 4'd0 || mac_b !== 4'd0) begin
                errors++;
                $display("FAIL bubble_gap%0d: a=%h b=%h required 0 0", i, mac_a, mac_b);
            end
            @(posedge clk); #1;
        end
        wait_count(c0 + 1);
        checks++;
        if (res_count != c0 + 1 || last_res !== 8'h22) begin
            errors++;
            $display("FAIL bubble_result: count=%0d last=%h required %0d 22", res_count, last_res, c0 + 1);
        end
    endtask

    task automatic test_backpressure;
        int c0 = res_count;
        res_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_pair(4'd15, 4'd15);
                send_pair(4'd2, 4'd3); send_pair(4'd2, 4'd3); send_pair(4'd1, 4'd1); send_pair(4'd4, 4'd5);
                for (int i = 0; i < 4; i++) send_pair(4'd1, 4'd1);
            end
            begin
                int t = 0;
                @(negedge clk);
                while (!res_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                checks++;
                if (res_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_first_result: valid=%b required 1", res_valid);
                end
                repeat (20) begin
                    @(negedge clk);
                    checks++;
                    if (res_valid !== 1'b1 || res_data !== 8'h84) begin
                        errors++;
                        $display("FAIL bp_hold: valid=%b data=%h required 1 84", res_valid, res_data);
                    end
                end
                checks++;
                if (in_ready !== 1'b0 || in_valid !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_full: in_ready=%b in_valid=%b busy=%b required 0 1 1", in_ready, in_valid, busy);
                end
                @(posedge clk); #1;
                res_ready = 1'b1;
            end
        join
        wait_count(c0 + 3);
        checks++;
        if (res_count != c0 + 3 || last_res !== 8'h04) begin
            errors++;
            $display("FAIL bp_drain: count=%0d last=%h required %0d 04", res_count, last_res, c0 + 3);
        end
    endtask

    task automatic test_reset_mid;
        res_ready = 1'b1;
        send_pair(4'd5, 4'd5);
        send_pair(4'd5, 4'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mac_rst !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_during: mac_rst=%b in_ready=%b required 1 0", mac_rst, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mac_a !== 4'd0 || mac_b !== 4'd0 || res_valid !== 1'b0 || res_data !== 8'd0 ||
            busy !== 1'b0 || in_ready !== 1'b1 || mac_rst !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after: a=%h b=%h rv=%b rd=%h busy=%b rdy=%b mrst=%b required 0 0 0 00 0 1 1",
                     mac_a, mac_b, res_valid, res_data, busy, in_ready, mac_rst);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_result;
        int t = 0;
        int c0 = res_count;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_pair(4'd1, 4'd1);
        for (int i = 0; i < 3; i++) send_pair(4'd9, 4'd9);
        @(negedge clk);
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_count != c0 || res_data !== 8'd0) begin
            errors++;
            $display("FAIL rstres_discard: rv=%b busy=%b count=%0d rd=%h required 0 0 %0d 00",
                     res_valid, busy, res_count, res_data, c0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_pair(4'd2, 4'd3);
        wait_count(c0 + 1);
        checks++;
        if (res_count != c0 + 1 || last_res !== 8'h18) begin
            errors++;
            $display("FAIL rstres_clean: count=%0d last=%h required %0d 18", res_count, last_res, c0 + 1);
        end
    endtask

    task automatic test_vec_len_one;
        int t = 0;
        res_ready1 = 1'b1;
        send_pair1(4'd7, 4'd9);
        send_pair1(4'd4, 4'd4);
        while (res1_n < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (res1_n != 2 || res1[0] !== 8'h3F || res1[1] !== 8'h10) begin
            errors++;
            $display("FAIL v1_sequence: n=%0d r0=%h r1=%h required 2 3f 10", res1_n, res1[0], res1[1]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; res_ready = 1'b1;
        in_valid1 = 1'b0; in_a1 = 4'd0; in_b1 = 4'd0; res_ready1 = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        test_reset_result();
        test_vec_len_one();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || exp1_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: q0=%0d q1=%0d required 0 0", exp_q.size(), exp1_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
